// File: rtl/instr_prefetch_decoder_pkg.sv
// Shared decoder definitions: addressing modes, reg_dest and instruction-type
// codes, ALU op codes, and the per-opcode field bundle produced by the table.
package instr_prefetch_decoder_pkg;

  // Addressing modes
  localparam logic [1:0] AM_IMPL = 2'd0;
  localparam logic [1:0] AM_IMM  = 2'd1;
  localparam logic [1:0] AM_ZP   = 2'd2;
  localparam logic [1:0] AM_ABS  = 2'd3;

  // Destination register codes
  localparam logic [2:0] RD_NONE = 3'd0;
  localparam logic [2:0] RD_A    = 3'd1;
  localparam logic [2:0] RD_X    = 3'd2;
  localparam logic [2:0] RD_Y    = 3'd3;
  localparam logic [2:0] RD_MEM  = 3'd4;

  // ALU operation codes
  localparam logic [4:0] ALU_OP_NOP = 5'd0;
  localparam logic [4:0] ALU_OP_ADD = 5'd1;
  localparam logic [4:0] ALU_OP_SUB = 5'd2;
  localparam logic [4:0] ALU_OP_AND = 5'd3;
  localparam logic [4:0] ALU_OP_OR  = 5'd4;
  localparam logic [4:0] ALU_OP_XOR = 5'd5;
  localparam logic [4:0] ALU_OP_SHL = 5'd6;
  localparam logic [4:0] ALU_OP_SHR = 5'd7;
  localparam logic [4:0] ALU_OP_ROL = 5'd8;
  localparam logic [4:0] ALU_OP_ROR = 5'd9;
  localparam logic [4:0] ALU_OP_INC = 5'd10;
  localparam logic [4:0] ALU_OP_DEC = 5'd11;

  // Instruction type codes
  localparam logic [7:0] I_LDA = 8'd0;
  localparam logic [7:0] I_LDX = 8'd1;
  localparam logic [7:0] I_LDY = 8'd2;
  localparam logic [7:0] I_STA = 8'd3;
  localparam logic [7:0] I_STX = 8'd4;
  localparam logic [7:0] I_STY = 8'd5;
  localparam logic [7:0] I_ADC = 8'd6;
  localparam logic [7:0] I_SBC = 8'd7;
  localparam logic [7:0] I_AND = 8'd8;
  localparam logic [7:0] I_ORA = 8'd9;
  localparam logic [7:0] I_XOR = 8'd10;
  localparam logic [7:0] I_ASL = 8'd11;
  localparam logic [7:0] I_LSR = 8'd12;
  localparam logic [7:0] I_ROL = 8'd13;
  localparam logic [7:0] I_ROR = 8'd14;
  localparam logic [7:0] I_INC = 8'd15;
  localparam logic [7:0] I_DEC = 8'd16;
  localparam logic [7:0] I_INX = 8'd17;
  localparam logic [7:0] I_DEX = 8'd18;
  localparam logic [7:0] I_INY = 8'd19;
  localparam logic [7:0] I_DEY = 8'd20;
  localparam logic [7:0] I_JMP = 8'd21;
  localparam logic [7:0] I_NOP = 8'd22;
  localparam logic [7:0] I_BEQ = 8'd23;
  localparam logic [7:0] I_BNE = 8'd24;
  localparam logic [7:0] I_BCS = 8'd25;
  localparam logic [7:0] I_BCC = 8'd26;
  localparam logic [7:0] I_BMI = 8'd27;
  localparam logic [7:0] I_BPL = 8'd28;
  localparam logic [7:0] I_BVC = 8'd29;
  localparam logic [7:0] I_BVS = 8'd30;

  // Decoded control fields for one opcode
  typedef struct packed {
    logic [4:0] alu_op;
    logic       use_alu;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] addr_mode;
    logic [1:0] size;
    logic [7:0] itype;
    logic [2:0] reg_dest;
  } dec_fields_t;

  // Packs one table row
  function automatic dec_fields_t fld(input logic [4:0] alu, input logic ua,
                                      input logic mr, input logic mw,
                                      input logic [1:0] am, input logic [1:0] sz,
                                      input logic [7:0] ty, input logic [2:0] rd);
    dec_fields_t f;
    f.alu_op    = alu;
    f.use_alu   = ua;
    f.mem_read  = mr;
    f.mem_write = mw;
    f.addr_mode = am;
    f.size      = sz;
    f.itype     = ty;
    f.reg_dest  = rd;
    return f;
  endfunction

endpackage

// File: rtl/instr_prefetch_decoder_opcode_table.sv
// Combinational opcode -> control-field lookup.
// Optional ILLEGAL_TRAP_EN adds an illegal flag for unknown opcodes.
module instr_prefetch_decoder_opcode_table
  import instr_prefetch_decoder_pkg::*;
(
  input  logic [7:0]  opcode_i,
  output dec_fields_t fields_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal_o
`endif
);

  // Table lookup; unknown opcodes fall back to a 1-byte NOP
  always_comb begin
    fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMPL, 2'd1, I_NOP, RD_NONE);
`ifdef ILLEGAL_TRAP_EN
    illegal_o = 1'b0;
`endif
    case (opcode_i)
      8'h0A: fields_o = fld(ALU_OP_SHL, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_ASL, RD_A);
      8'h4A: fields_o = fld(ALU_OP_SHR, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_LSR, RD_A);
      8'h2A: fields_o = fld(ALU_OP_ROL, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_ROL, RD_A);
      8'h6A: fields_o = fld(ALU_OP_ROR, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_ROR, RD_A);
      8'hA9: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_LDA, RD_A);
      8'hA5: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b1, 1'b0, AM_ZP,   2'd2, I_LDA, RD_A);
      8'hAD: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b1, 1'b0, AM_ABS,  2'd3, I_LDA, RD_A);
      8'hA2: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_LDX, RD_X);
      8'hA6: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b1, 1'b0, AM_ZP,   2'd2, I_LDX, RD_X);
      8'hAE: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b1, 1'b0, AM_ABS,  2'd3, I_LDX, RD_X);
      8'hA0: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_LDY, RD_Y);
      8'hA4: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b1, 1'b0, AM_ZP,   2'd2, I_LDY, RD_Y);
      8'h85: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b1, AM_ZP,   2'd2, I_STA, RD_A);
      8'h8D: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b1, AM_ABS,  2'd3, I_STA, RD_A);
      8'h86: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b1, AM_ZP,   2'd2, I_STX, RD_X);
      8'h84: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b1, AM_ZP,   2'd2, I_STY, RD_Y);
      8'h69: fields_o = fld(ALU_OP_ADD, 1'b1, 1'b0, 1'b0, AM_IMM,  2'd2, I_ADC, RD_A);
      8'h65: fields_o = fld(ALU_OP_ADD, 1'b1, 1'b1, 1'b0, AM_ZP,   2'd2, I_ADC, RD_A);
      8'hE9: fields_o = fld(ALU_OP_SUB, 1'b1, 1'b0, 1'b0, AM_IMM,  2'd2, I_SBC, RD_A);
      8'hE5: fields_o = fld(ALU_OP_SUB, 1'b1, 1'b1, 1'b0, AM_ZP,   2'd2, I_SBC, RD_A);
      8'h29: fields_o = fld(ALU_OP_AND, 1'b1, 1'b0, 1'b0, AM_IMM,  2'd2, I_AND, RD_A);
      8'h25: fields_o = fld(ALU_OP_AND, 1'b1, 1'b1, 1'b0, AM_ZP,   2'd2, I_AND, RD_A);
      8'h49: fields_o = fld(ALU_OP_XOR, 1'b1, 1'b0, 1'b0, AM_IMM,  2'd2, I_XOR, RD_A);
      8'h45: fields_o = fld(ALU_OP_XOR, 1'b1, 1'b1, 1'b0, AM_ZP,   2'd2, I_XOR, RD_A);
      8'h09: fields_o = fld(ALU_OP_OR,  1'b1, 1'b0, 1'b0, AM_IMM,  2'd2, I_ORA, RD_A);
      8'h05: fields_o = fld(ALU_OP_OR,  1'b1, 1'b1, 1'b0, AM_ZP,   2'd2, I_ORA, RD_A);
      8'hE6: fields_o = fld(ALU_OP_INC, 1'b1, 1'b1, 1'b1, AM_ZP,   2'd2, I_INC, RD_MEM);
      8'hC6: fields_o = fld(ALU_OP_DEC, 1'b1, 1'b1, 1'b1, AM_ZP,   2'd2, I_DEC, RD_MEM);
      8'h4C: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_ABS,  2'd3, I_JMP, RD_NONE);
      8'hF0: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BEQ, RD_NONE);
      8'hD0: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BNE, RD_NONE);
      8'hB0: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BCS, RD_NONE);
      8'h90: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BCC, RD_NONE);
      8'h30: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BMI, RD_NONE);
      8'h10: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BPL, RD_NONE);
      8'h50: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BVC, RD_NONE);
      8'h70: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMM,  2'd2, I_BVS, RD_NONE);
      8'hE8: fields_o = fld(ALU_OP_INC, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_INX, RD_X);
      8'hCA: fields_o = fld(ALU_OP_DEC, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_DEX, RD_X);
      8'hC8: fields_o = fld(ALU_OP_INC, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_INY, RD_Y);
      8'h88: fields_o = fld(ALU_OP_DEC, 1'b1, 1'b0, 1'b0, AM_IMPL, 2'd1, I_DEY, RD_Y);
      8'hEA: fields_o = fld(ALU_OP_NOP, 1'b0, 1'b0, 1'b0, AM_IMPL, 2'd1, I_NOP, RD_NONE);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_o = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/instr_prefetch_decoder.sv
// Prefetch FIFO + instruction assembler + registered decoded bundle.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes raise dec_illegal and halt
// emission until flush.
module instr_prefetch_decoder
  import instr_prefetch_decoder_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        PC_W     = 16,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  input  logic            byte_valid,
  input  logic [7:0]      byte_data,
  output logic            byte_ready,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [PC_W-1:0] dec_pc,
  output logic [7:0]      dec_opcode,
  output logic [15:0]     dec_operand,
  output logic [4:0]      dec_alu_op,
  output logic            dec_use_alu,
  output logic            dec_mem_read,
  output logic            dec_mem_write,
  output logic [1:0]      dec_addr_mode,
  output logic [1:0]      dec_size,
  output logic [7:0]      dec_type,
  output logic [2:0]      dec_reg_dest
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            dec_illegal
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             byte_ready_q, byte_ready_d;
  logic             dec_valid_q, dec_valid_d;
  logic [PC_W-1:0]  dec_pc_q, dec_pc_d;
  logic [7:0]       dec_opcode_q, dec_opcode_d;
  logic [15:0]      dec_operand_q, dec_operand_d;
  dec_fields_t      dec_f_q, dec_f_d;
  dec_fields_t      tbl_f;
  logic [7:0]       b0, b1, b2;
  logic [15:0]      operand;
  logic             push, emit, trap_stall;

  // Head window: opcode and up to two operand bytes, wrapping the buffer
  assign b0 = mem_q[rd_ptr_q];
  assign b1 = mem_q[rd_ptr_q + PTR_W'(1)];
  assign b2 = mem_q[rd_ptr_q + PTR_W'(2)];

`ifdef ILLEGAL_TRAP_EN
  logic tbl_illegal;
  logic halt_q, halt_d;
  logic dec_illegal_q, dec_illegal_d;
  assign trap_stall  = halt_q;
  assign dec_illegal = dec_illegal_q;

  instr_prefetch_decoder_opcode_table u_table (
    .opcode_i  (b0),
    .fields_o  (tbl_f),
    .illegal_o (tbl_illegal)
  );
`else
  assign trap_stall = 1'b0;

  instr_prefetch_decoder_opcode_table u_table (
    .opcode_i (b0),
    .fields_o (tbl_f)
  );
`endif

  assign push = byte_valid && byte_ready_q && !flush;
  assign emit = !flush && !trap_stall && (count_q >= CNT_W'(tbl_f.size))
                && (!dec_valid_q || dec_ready);

  // Little-endian operand assembly by instruction length
  always_comb begin
    case (tbl_f.size)
      2'd3:    operand = {b2, b1};
      2'd2:    operand = {8'h00, b1};
      default: operand = 16'h0000;
    endcase
  end

  // Next-state: FIFO pointers/count, head PC, output bundle; flush dominates
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    pc_d          = pc_q;
    dec_valid_d   = dec_valid_q;
    dec_pc_d      = dec_pc_q;
    dec_opcode_d  = dec_opcode_q;
    dec_operand_d = dec_operand_q;
    dec_f_d       = dec_f_q;
`ifdef ILLEGAL_TRAP_EN
    halt_d        = halt_q;
    dec_illegal_d = dec_illegal_q;
`endif
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - (emit ? CNT_W'(tbl_f.size) : CNT_W'(0));
    if (emit) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(tbl_f.size);
      pc_d          = pc_q + PC_W'(tbl_f.size);
      dec_valid_d   = 1'b1;
      dec_pc_d      = pc_q;
      dec_opcode_d  = b0;
      dec_operand_d = operand;
      dec_f_d       = tbl_f;
`ifdef ILLEGAL_TRAP_EN
      dec_illegal_d = tbl_illegal;
      halt_d        = tbl_illegal;
`endif
    end else if (dec_valid_q && dec_ready) begin
      dec_valid_d = 1'b0;
    end
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      pc_d        = flush_pc;
      dec_valid_d = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      halt_d      = 1'b0;
`endif
    end
    byte_ready_d = (count_d < CNT_W'(DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      pc_q          <= RESET_PC;
      byte_ready_q  <= 1'b1;
      dec_valid_q   <= 1'b0;
      dec_pc_q      <= '0;
      dec_opcode_q  <= '0;
      dec_operand_q <= '0;
      dec_f_q       <= '0;
`ifdef ILLEGAL_TRAP_EN
      halt_q        <= 1'b0;
      dec_illegal_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      byte_ready_q  <= byte_ready_d;
      dec_valid_q   <= dec_valid_d;
      dec_pc_q      <= dec_pc_d;
      dec_opcode_q  <= dec_opcode_d;
      dec_operand_q <= dec_operand_d;
      dec_f_q       <= dec_f_d;
`ifdef ILLEGAL_TRAP_EN
      halt_q        <= halt_d;
      dec_illegal_q <= dec_illegal_d;
`endif
    end
  end

  // Byte storage; contents are only read behind the count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_data;
  end

  assign byte_ready    = byte_ready_q;
  assign dec_valid     = dec_valid_q;
  assign dec_pc        = dec_pc_q;
  assign dec_opcode    = dec_opcode_q;
  assign dec_operand   = dec_operand_q;
  assign dec_alu_op    = dec_f_q.alu_op;
  assign dec_use_alu   = dec_f_q.use_alu;
  assign dec_mem_read  = dec_f_q.mem_read;
  assign dec_mem_write = dec_f_q.mem_write;
  assign dec_addr_mode = dec_f_q.addr_mode;
  assign dec_size      = dec_f_q.size;
  assign dec_type      = dec_f_q.itype;
  assign dec_reg_dest  = dec_f_q.reg_dest;

endmodule
